regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
// - Parametrised integer register file for the 5-stage pipeline: two combinational read ports, one write port.
// - Replaces the fixed 32x64 file; adds register 0 hardwired to zero and an asynchronous clear of all registers.
// - Adds a per-register busy scoreboard: set when ID issues an instruction with a destination, cleared at WB.
// - Hazard unit uses rs1_busy/rs2_busy to stall or forward; ID reads operands, WB writes results.
// PARAMETERS
// - DATA_W    64   register width in bits
// - NUM_REGS  32   register count, power of two, >= 2
// - AW        $clog2(NUM_REGS)   localparam, address width
// PORTS
// - clk       in   1         single clock; every state change on rising edge
// - reset     in   1         asynchronous, active-high
// - rs1_addr  in   AW        read port 1 address
// - rs2_addr  in   AW        read port 2 address
// - rd_data1  out  DATA_W    read port 1 data
// - rd_data2  out  DATA_W    read port 2 data
// - rs1_busy  out  1         pending write to rs1_addr
// - rs2_busy  out  1         pending write to rs2_addr
// - wr_en     in   1         WB write strobe
// - wr_addr   in   AW        WB destination
// - wr_data   in   DATA_W    WB result
// - iss_en    in   1         ID issue of an instruction that writes a register
// - iss_rd    in   AW        destination of issued instruction
// - busy_vec  out  NUM_REGS  full scoreboard, bit i = register i busy
// BEHAVIOUR
// - One clock, clk; reset is asynchronous and active-high.
// - Reset: all registers <= 0 and busy_vec <= 0 immediately, without waiting for a clock edge.
//   - rd_data1/2 = 0 and rs1/rs2_busy = 0 for as long as reset is high.
//   - A write or issue coinciding with reset is discarded.
// - Read: combinational from array; zero-cycle latency. Address 0 always returns 0.
// - Write: at posedge clk, if wr_en && wr_addr != 0, then Reg[wr_addr] <= wr_data. A write to address 0 is ignored.
// - Scoreboard update at posedge clk, per register i != 0:
//   - set   = iss_en && iss_rd == i
//   - clear = wr_en && wr_addr == i
//   - busy[i] <= set ? 1 : (clear ? 0 : busy[i])
//   - Issue wins over a same-cycle clear on the same register: a new producer supersedes the one retiring.
//   - busy[0] is constant 0; issue to or write of register 0 has no scoreboard effect.
// - The scoreboard is a flag, not a counter. A second issue to a busy register leaves it busy. The first
//   matching write clears it. The pipeline is in-order, so ordering is guaranteed upstream.
// - rsN_busy = busy[rsN_addr] (subject to bypass below). Both ports may address the same register; both see identical results.
// CONFIGURATION
// - REGFILE_BYPASS_EN defined: same-cycle write-through forwarding.
//   - If wr_en && wr_addr == rsN_addr && rsN_addr != 0: rd_dataN = wr_data and rsN_busy = 0, unless the
//     same cycle also issues to that register, in which case rsN_busy = busy.
//   - This covers the WB->ID hazard that the old negedge write handled.
// - REGFILE_BYPASS_EN undefined: reads return stored array contents and busy reflects registered
//   busy_vec only. The new value and cleared busy become visible the cycle after the write.
// - busy_vec is always the registered state, unaffected by the macro.
// TESTING
// - Reset pulse mid-cycle (no clk edge), after writing R5=0x1234:
//   -> rd_data of R5 reads 0 immediately; busy_vec=0.
// - wr_en, wr_addr=0, wr_data=0xFFFF; then read rs1=0
//   -> rd_data1=0; busy_vec[0]=0 even with iss_rd=0.
// - iss_en, iss_rd=7; next cycle rs1_addr=7 -> rs1_busy=1.
//   Then wr_en, wr_addr=7, wr_data=0xABCD:
//   -> with BYPASS_EN, rd_data1=0xABCD and rs1_busy=0 in the same cycle;
//   -> without it, both update one cycle later.
// - Same edge: iss_en, iss_rd=9 and wr_en, wr_addr=9 with busy[9]=1
//   -> after the edge busy[9]=1 and Reg[9]=wr_data.
// - rs1_addr=rs2_addr=3 after Reg[3]=0x42
//   -> rd_data1=rd_data2=0x42 and rs1_busy=rs2_busy.
// - Regression at DATA_W=32, NUM_REGS=16: fill all registers with index*3
//   -> readback matches; register 0 reads 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with per-register busy scoreboard for the 5-stage pipeline.
// Two combinational read ports, one WB write port, R0 hardwired to zero, async clear.
//
// Parameters: DATA_W (register width), NUM_REGS (power of two, >= 2).
// Ports:
//   clk, reset           - clock, asynchronous active-high clear of registers and busy flags
//   rs1_addr/rs2_addr    - read addresses; rd_data1/rd_data2 data, rs1_busy/rs2_busy pending write
//   wr_en/wr_addr/wr_data- WB write; also retires the busy flag of wr_addr
//   iss_en/iss_rd        - ID issue of a register-writing instruction; marks iss_rd busy
//   busy_vec             - registered scoreboard, bit i = register i busy
// Build option: define REGFILE_BYPASS_EN for same-cycle WB->ID write-through forwarding.
module regfile_scoreboard #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     rs1_addr,
    input  logic [AW-1:0]     rs2_addr,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [DATA_W-1:0]   stored1;
    logic [DATA_W-1:0]   stored2;

    // Register array; entry 0 is cleared on reset and never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A new issue supersedes a retiring write to the same register.
    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (iss_en && iss_rd == AW'(i)) begin
                busy_nxt[i] = 1'b1;
            end else if (wr_en && wr_addr == AW'(i)) begin
                busy_nxt[i] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign busy_vec = busy;

    assign stored1 = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign stored2 = (rs2_addr == '0) ? '0 : regs[rs2_addr];

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;
    logic iss_hit1;
    logic iss_hit2;

    // Forward the WB result into ID in the same cycle; busy only drops
    // if no new producer is issuing to that register this cycle.
    assign fwd1     = wr_en && wr_addr == rs1_addr && rs1_addr != '0;
    assign fwd2     = wr_en && wr_addr == rs2_addr && rs2_addr != '0;
    assign iss_hit1 = iss_en && iss_rd == rs1_addr;
    assign iss_hit2 = iss_en && iss_rd == rs2_addr;

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (!reset) begin
            rd_data1 = fwd1 ? wr_data : stored1;
            rd_data2 = fwd2 ? wr_data : stored2;
            rs1_busy = (fwd1 && !iss_hit1) ? 1'b0 : busy[rs1_addr];
            rs2_busy = (fwd2 && !iss_hit2) ? 1'b0 : busy[rs2_addr];
        end
    end
`else
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (!reset) begin
            rd_data1 = stored1;
            rd_data2 = stored2;
            rs1_busy = busy[rs1_addr];
            rs2_busy = busy[rs2_addr];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard.
// Checks the default 64x32 build and a 32x16 instance.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic [4:0]  rs1_addr, rs2_addr, wr_addr, iss_rd;
    logic [63:0] rd_data1, rd_data2, wr_data;
    logic        rs1_busy, rs2_busy, wr_en, iss_en;
    logic [31:0] busy_vec;

    logic [3:0]  s_rs1, s_rs2, s_wa, s_iss;
    logic [31:0] s_rd1, s_rd2, s_wd;
    logic        s_b1, s_b2, s_we, s_ie;
    logic [15:0] s_bv;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(64), .NUM_REGS(32)) u_dut (
        .clk(clk), .reset(reset),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy_vec(busy_vec)
    );

    regfile_scoreboard #(.DATA_W(32), .NUM_REGS(16)) u_dut16 (
        .clk(clk), .reset(reset),
        .rs1_addr(s_rs1), .rs2_addr(s_rs2),
        .rd_data1(s_rd1), .rd_data2(s_rd2),
        .rs1_busy(s_b1), .rs2_busy(s_b2),
        .wr_en(s_we), .wr_addr(s_wa), .wr_data(s_wd),
        .iss_en(s_ie), .iss_rd(s_iss), .busy_vec(s_bv)
    );

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        iss_en = 0; iss_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1;
        #1;
        total++;
        if (busy_vec !== 32'h0) begin
            bad++; $display("FAIL reset_busy got=%h exp=0", busy_vec);
        end
        tick();
        reset = 0;
        wr_en = 1; wr_addr = 5; wr_data = 64'h1234;
        iss_en = 1; iss_rd = 5;
        tick();
        idle();
        rs1_addr = 5;
        #1;
        total++;
        if (rd_data1 !== 64'h1234 || busy_vec !== 32'h20) begin
            bad++; $display("FAIL pre_reset got=%h/%h exp=1234/20", rd_data1, busy_vec);
        end
        #1 reset = 1;
        #1;
        total++;
        if (rd_data1 !== 64'h0 || busy_vec !== 32'h0 || rs1_busy !== 1'b0) begin
            bad++; $display("FAIL midcycle_reset got=%h/%h/%b exp=0/0/0", rd_data1, busy_vec, rs1_busy);
        end
        #1 reset = 0;
        // write and issue while reset is held across an edge
        @(negedge clk);
        reset = 1;
        wr_en = 1; wr_addr = 6; wr_data = 64'h66;
        iss_en = 1; iss_rd = 6;
        tick();
        reset = 0;
        idle();
        rs1_addr = 6;
        #1;
        total++;
        if (rd_data1 !== 64'h0 || busy_vec !== 32'h0) begin
            bad++; $display("FAIL reset_discard got=%h/%h exp=0/0", rd_data1, busy_vec);
        end
    endtask

    task automatic test_zero();
        tick();
        wr_en = 1; wr_addr = 0; wr_data = 64'hFFFF;
        iss_en = 1; iss_rd = 0;
        tick();
        idle();
        rs1_addr = 0;
        #1;
        total++;
        if (rd_data1 !== 64'h0) begin
            bad++; $display("FAIL r0_read got=%h exp=0", rd_data1);
        end
        total++;
        if (busy_vec !== 32'h0) begin
            bad++; $display("FAIL r0_busy got=%h exp=0", busy_vec);
        end
    endtask

    task automatic test_busy();
        tick();
        iss_en = 1; iss_rd = 7;
        tick();
        idle();
        rs1_addr = 7;
        #1;
        total++;
        if (rs1_busy !== 1'b1 || busy_vec !== 32'h80) begin
            bad++; $display("FAIL busy_set got=%b/%h exp=1/80", rs1_busy, busy_vec);
        end
        wr_en = 1; wr_addr = 7; wr_data = 64'hABCD;
        #1;
        total++;
`ifdef REGFILE_BYPASS_EN
        if (rd_data1 !== 64'hABCD || rs1_busy !== 1'b0) begin
            bad++; $display("FAIL wb_same got=%h/%b exp=abcd/0", rd_data1, rs1_busy);
        end
`else
        if (rd_data1 !== 64'h0 || rs1_busy !== 1'b1) begin
            bad++; $display("FAIL wb_same got=%h/%b exp=0/1", rd_data1, rs1_busy);
        end
`endif
        total++;
        if (busy_vec !== 32'h80) begin
            bad++; $display("FAIL busy_vec_reg got=%h exp=80", busy_vec);
        end
        tick();
        idle();
        #1;
        total++;
        if (rd_data1 !== 64'hABCD || rs1_busy !== 1'b0 || busy_vec !== 32'h0) begin
            bad++; $display("FAIL wb_next got=%h/%b/%h exp=abcd/0/0", rd_data1, rs1_busy, busy_vec);
        end
    endtask

    task automatic test_issue_wins();
        iss_en = 1; iss_rd = 9;
        tick();
        idle();
        rs1_addr = 9;
        iss_en = 1; iss_rd = 9;
        wr_en = 1; wr_addr = 9; wr_data = 64'h99;
        #1;
        total++;
`ifdef REGFILE_BYPASS_EN
        if (rd_data1 !== 64'h99 || rs1_busy !== 1'b1) begin
            bad++; $display("FAIL iss_wr_same got=%h/%b exp=99/1", rd_data1, rs1_busy);
        end
`else
        if (rd_data1 !== 64'h0 || rs1_busy !== 1'b1) begin
            bad++; $display("FAIL iss_wr_same got=%h/%b exp=0/1", rd_data1, rs1_busy);
        end
`endif
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 32'h200 || rd_data1 !== 64'h99) begin
            bad++; $display("FAIL iss_wins got=%h/%h exp=200/99", busy_vec, rd_data1);
        end
        wr_en = 1; wr_addr = 9; wr_data = 64'h99;
        tick();
        idle();
    endtask

    task automatic test_dual_port();
        wr_en = 1; wr_addr = 3; wr_data = 64'h42;
        iss_en = 1; iss_rd = 4;
        tick();
        idle();
        rs1_addr = 3; rs2_addr = 3;
        #1;
        total++;
        if (rd_data1 !== 64'h42 || rd_data2 !== 64'h42) begin
            bad++; $display("FAIL dual_data got=%h/%h exp=42/42", rd_data1, rd_data2);
        end
        total++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
            bad++; $display("FAIL dual_busy got=%b/%b exp=0/0", rs1_busy, rs2_busy);
        end
        rs1_addr = 4; rs2_addr = 4;
        #1;
        total++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1 || busy_vec !== 32'h10) begin
            bad++; $display("FAIL dual_busy4 got=%b/%b/%h exp=1/1/10", rs1_busy, rs2_busy, busy_vec);
        end
        wr_en = 1; wr_addr = 4; wr_data = 64'h4;
        tick();
        idle();
    endtask

    task automatic test_flag();
        iss_en = 1; iss_rd = 11;
        tick();
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 32'h800) begin
            bad++; $display("FAIL flag_twice got=%h exp=800", busy_vec);
        end
        wr_en = 1; wr_addr = 11; wr_data = 64'hB;
        tick();
        idle();
        #1;
        total++;
        if (busy_vec !== 32'h0) begin
            bad++; $display("FAIL flag_clear got=%h exp=0", busy_vec);
        end
    endtask

    task automatic test_regress16();
        for (int i = 0; i < 16; i++) begin
            s_we = 1; s_wa = 4'(i); s_wd = 32'(i * 3);
            tick();
        end
        s_we = 0;
        for (int i = 0; i < 16; i++) begin
            s_rs1 = 4'(i); s_rs2 = 4'(15 - i);
            #1;
            total++;
            if (s_rd1 !== 32'(i * 3) && i != 0) begin
                bad++; $display("FAIL r16_read%0d got=%h exp=%h", i, s_rd1, 32'(i * 3));
            end else if (i == 0 && s_rd1 !== 32'h0) begin
                bad++; $display("FAIL r16_r0 got=%h exp=0", s_rd1);
            end
            total++;
            if (s_rd2 !== ((i == 15) ? 32'h0 : 32'((15 - i) * 3))) begin
                bad++; $display("FAIL r16_port2_%0d got=%h", i, s_rd2);
            end
        end
        total++;
        if (s_bv !== 16'h0) begin
            bad++; $display("FAIL r16_busy got=%h exp=0", s_bv);
        end
    endtask

    initial begin
        idle();
        rs1_addr = 0; rs2_addr = 0;
        s_rs1 = 0; s_rs2 = 0; s_we = 0; s_wa = 0; s_wd = 0;
        s_ie = 0; s_iss = 0;
        #2;
        test_reset();
        test_zero();
        test_busy();
        test_issue_wins();
        test_dual_port();
        test_flag();
        test_regress16();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
